// File: rtl/seg_scan_driver.sv
// Multiplexed hex seven-segment scanner. Digit content is double-buffered so that
// a load only becomes visible at a frame boundary. Per-digit enable, blink, decimal-point
// and leading-zero blanking are supported.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   enable_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_blank,
   output logic [7:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o,
   output logic                    pending_o
);

   localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
   localparam int DIV_W   = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

   logic [DIV_W-1:0]        divCnt_q, divCnt_d;
   logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
   logic [BLINK_W-1:0]      blinkCnt_q, blinkCnt_d;
   logic                    blinkPhase_q, blinkPhase_d;
   logic                    pending_q, pending_d;

   logic [4*NUM_DIGITS-1:0] shData_q, shData_d;
   logic [NUM_DIGITS-1:0]   shEnable_q, shEnable_d;
   logic [NUM_DIGITS-1:0]   shBlink_q, shBlink_d;
   logic [NUM_DIGITS-1:0]   shDp_q, shDp_d;
   logic                    shLz_q, shLz_d;

   logic [4*NUM_DIGITS-1:0] actData_q, actData_d;
   logic [NUM_DIGITS-1:0]   actEnable_q, actEnable_d;
   logic [NUM_DIGITS-1:0]   actBlink_q, actBlink_d;
   logic [NUM_DIGITS-1:0]   actDp_q, actDp_d;
   logic                    actLz_q, actLz_d;

   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    divWrap;
   logic                    frameEnd;
   logic [NUM_DIGITS-1:0]   lzBlank;
   logic                    zeroRun;
   logic [3:0]              nibble;
   logic                    curEnable, curBlink, curDp, curLz;
   logic [NUM_DIGITS-1:0]   anOneHot;

   function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
      logic [6:0] segs;
      case (hex)
         4'h0: segs = 7'h3F;
         4'h1: segs = 7'h06;
         4'h2: segs = 7'h5B;
         4'h3: segs = 7'h4F;
         4'h4: segs = 7'h66;
         4'h5: segs = 7'h6D;
         4'h6: segs = 7'h7D;
         4'h7: segs = 7'h07;
         4'h8: segs = 7'h7F;
         4'h9: segs = 7'h6F;
         4'hA: segs = 7'h77;
         4'hB: segs = 7'h7C;
         4'hC: segs = 7'h39;
         4'hD: segs = 7'h5E;
         4'hE: segs = 7'h79;
         default: segs = 7'h71;
      endcase
      return segs;
   endfunction

   // Scan timing: prescaler, digit index and the blink half-period counter.
   always_comb begin
      divWrap      = (divCnt_q == LAST_DIV);
      frameEnd     = divWrap && (digitIdx_q == LAST_IDX);
      divCnt_d     = divWrap ? '0 : divCnt_q + 1'b1;
      digitIdx_d   = digitIdx_q;
      blinkCnt_d   = blinkCnt_q;
      blinkPhase_d = blinkPhase_q;
      if (divWrap) begin
         digitIdx_d = (digitIdx_q == LAST_IDX) ? '0 : digitIdx_q + 1'b1;
      end
      if (frameEnd) begin
         if (blinkCnt_q == LAST_BLINK) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
      end
   end

   // A load in the frame-end cycle lands in the shadow after the old shadow has been promoted.
   always_comb begin
      shData_d    = shData_q;
      shEnable_d  = shEnable_q;
      shBlink_d   = shBlink_q;
      shDp_d      = shDp_q;
      shLz_d      = shLz_q;
      actData_d   = actData_q;
      actEnable_d = actEnable_q;
      actBlink_d  = actBlink_q;
      actDp_d     = actDp_q;
      actLz_d     = actLz_q;
      pending_d   = pending_q;
      if (frameEnd && pending_q) begin
         actData_d   = shData_q;
         actEnable_d = shEnable_q;
         actBlink_d  = shBlink_q;
         actDp_d     = shDp_q;
         actLz_d     = shLz_q;
         pending_d   = 1'b0;
      end
      if (load) begin
         shData_d   = data_in;
         shEnable_d = enable_mask;
         shBlink_d  = blink_mask;
         shDp_d     = dp_mask;
         shLz_d     = lz_blank;
         pending_d  = 1'b1;
      end
   end

   // Leading zeros are blanked from the top digit down; digit 0 always shows.
   always_comb begin
      lzBlank = '0;
      zeroRun = actLz_q;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zeroRun    = zeroRun && (actData_q[4*i +: 4] == 4'h0);
         lzBlank[i] = zeroRun && (i != 0);
      end
   end

   always_comb begin
      nibble    = 4'h0;
      curEnable = 1'b0;
      curBlink  = 1'b0;
      curDp     = 1'b0;
      curLz     = 1'b0;
      anOneHot  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digitIdx_q == IDX_W'(i)) begin
            nibble      = actData_q[4*i +: 4];
            curEnable   = actEnable_q[i];
            curBlink    = actBlink_q[i];
            curDp       = actDp_q[i];
            curLz       = lzBlank[i];
            anOneHot[i] = 1'b1;
         end
      end
      seg_d = {curDp, hexToSeg(nibble)};
      an_d  = anOneHot;
      if (curLz) begin
         seg_d[6:0] = 7'h00;
      end
      if (blinkPhase_q && curBlink) begin
         seg_d = 8'h00;
      end
      if (!curEnable) begin
         seg_d = 8'h00;
         an_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt_q     <= '0;
         digitIdx_q   <= '0;
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
         pending_q    <= 1'b0;
         shData_q     <= '0;
         shEnable_q   <= '0;
         shBlink_q    <= '0;
         shDp_q       <= '0;
         shLz_q       <= 1'b0;
         actData_q    <= '0;
         actEnable_q  <= '1;
         actBlink_q   <= '0;
         actDp_q      <= '0;
         actLz_q      <= 1'b0;
         seg_q        <= 8'h00;
         an_q         <= '0;
      end else begin
         divCnt_q     <= divCnt_d;
         digitIdx_q   <= digitIdx_d;
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
         pending_q    <= pending_d;
         shData_q     <= shData_d;
         shEnable_q   <= shEnable_d;
         shBlink_q    <= shBlink_d;
         shDp_q       <= shDp_d;
         shLz_q       <= shLz_d;
         actData_q    <= actData_d;
         actEnable_q  <= actEnable_d;
         actBlink_q   <= actBlink_d;
         actDp_q      <= actDp_d;
         actLz_q      <= actLz_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg_o     = seg_q;
   assign an_o      = an_q;
   assign frame_o   = frameEnd;
   assign pending_o = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 8 digits, 4 clocks per digit, 2 frames per blink phase.
// Cycle n is the interval after the n-th rising edge following reset release; all I/O happens at falling edges.
module tb_seg_scan_driver;

   logic        clk;
   logic        rst;
   logic        load;
   logic [31:0] data_in;
   logic [7:0]  enable_mask;
   logic [7:0]  blink_mask;
   logic [7:0]  dp_mask;
   logic        lz_blank;
   logic [7:0]  seg_o;
   logic [7:0]  an_o;
   logic        frame_o;
   logic        pending_o;

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;

   seg_scan_driver #(
      .NUM_DIGITS  (8),
      .SCAN_DIV    (4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .data_in    (data_in),
      .enable_mask(enable_mask),
      .blink_mask (blink_mask),
      .dp_mask    (dp_mask),
      .lz_blank   (lz_blank),
      .seg_o      (seg_o),
      .an_o       (an_o),
      .frame_o    (frame_o),
      .pending_o  (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepTo(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst         = 1'b1;
      load        = 1'b0;
      data_in     = '0;
      enable_mask = '0;
      blink_mask  = '0;
      dp_mask     = '0;
      lz_blank    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   // One-cycle load pulse presented during cycle n.
   task automatic applyStimulus(input int n, input logic [31:0] data, input logic [7:0] en,
                                input logic [7:0] blink, input logic [7:0] dp, input logic lz);
      stepTo(n);
      load        = 1'b1;
      data_in     = data;
      enable_mask = en;
      blink_mask  = blink;
      dp_mask     = dp;
      lz_blank    = lz;
      stepTo(n + 1);
      load = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      load        = 1'b0;
      data_in     = '0;
      enable_mask = '0;
      blink_mask  = '0;
      dp_mask     = '0;
      lz_blank    = 1'b0;

      // Reset release and free-running scan of the default all-'0' display.
      doReset();
      checkOutput("rst seg", seg_o, 8'h00);
      checkOutput("rst an", an_o, 8'h00);
      checkOutput("rst pending", pending_o, 1'b0);
      checkOutput("rst frame", frame_o, 1'b0);
      for (int c = 1; c <= 36; c++) begin
         stepTo(c);
         checkOutput($sformatf("walk c%0d an", c), an_o, 8'h01 << (((c - 1) / 4) % 8));
         checkOutput($sformatf("walk c%0d seg", c), seg_o, 8'h3F);
         checkOutput($sformatf("walk c%0d frame", c), frame_o, (c % 32) == 31);
      end

      // Leading-zero blanking of 0x000000A8.
      doReset();
      applyStimulus(2, 32'h0000_00A8, 8'hFF, 8'h00, 8'h00, 1'b1);
      checkOutput("lz pending set", pending_o, 1'b1);
      stepTo(31);
      checkOutput("lz frame end", frame_o, 1'b1);
      stepTo(32);
      checkOutput("lz pending clr", pending_o, 1'b0);
      stepTo(33);
      checkOutput("lz d0 seg", seg_o, 8'h7F);
      stepTo(37);
      checkOutput("lz d1 seg", seg_o, 8'h77);
      stepTo(41);
      checkOutput("lz d2 seg", seg_o, 8'h00);
      checkOutput("lz d2 an", an_o, 8'h04);
      stepTo(61);
      checkOutput("lz d7 seg", seg_o, 8'h00);
      checkOutput("lz d7 an", an_o, 8'h80);

      // Two loads in one frame: last one wins, nothing shows until the frame end.
      doReset();
      applyStimulus(5, 32'h1111_1111, 8'hFF, 8'h00, 8'h00, 1'b0);
      checkOutput("dbl pending c6", pending_o, 1'b1);
      applyStimulus(9, 32'h2222_2222, 8'hFF, 8'h00, 8'h00, 1'b0);
      stepTo(21);
      checkOutput("dbl midframe seg", seg_o, 8'h3F);
      stepTo(30);
      checkOutput("dbl pending c30", pending_o, 1'b1);
      stepTo(33);
      checkOutput("dbl d0 seg", seg_o, 8'h5B);
      checkOutput("dbl d0 an", an_o, 8'h01);
      checkOutput("dbl pending clr", pending_o, 1'b0);
      stepTo(45);
      checkOutput("dbl d3 seg", seg_o, 8'h5B);

      // Load colliding with the frame-end cycle.
      doReset();
      applyStimulus(10, 32'h1111_1111, 8'hFF, 8'h00, 8'h00, 1'b0);
      stepTo(31);
      checkOutput("fe frame", frame_o, 1'b1);
      applyStimulus(31, 32'h4444_4444, 8'hFF, 8'h00, 8'h00, 1'b0);
      checkOutput("fe pending kept", pending_o, 1'b1);
      stepTo(33);
      checkOutput("fe old shadow seg", seg_o, 8'h06);
      stepTo(64);
      checkOutput("fe pending clr", pending_o, 1'b0);
      stepTo(65);
      checkOutput("fe new seg", seg_o, 8'h66);

      // Blinking digit 0.
      doReset();
      applyStimulus(0, 32'h0000_0000, 8'hFF, 8'h01, 8'h00, 1'b0);
      checkOutput("blink f0 seg", seg_o, 8'h3F);
      stepTo(33);
      checkOutput("blink f1 seg", seg_o, 8'h3F);
      stepTo(65);
      checkOutput("blink f2 seg", seg_o, 8'h00);
      checkOutput("blink f2 an", an_o, 8'h01);
      stepTo(69);
      checkOutput("blink f2 d1 seg", seg_o, 8'h3F);
      stepTo(97);
      checkOutput("blink f3 seg", seg_o, 8'h00);
      stepTo(129);
      checkOutput("blink f4 seg", seg_o, 8'h3F);
      stepTo(161);
      checkOutput("blink f5 seg", seg_o, 8'h3F);

      // Disabled digit, decimal point, then reset discarding a pending update.
      doReset();
      applyStimulus(2, 32'h1234_5678, 8'hFE, 8'h00, 8'h02, 1'b0);
      stepTo(33);
      checkOutput("dis d0 an", an_o, 8'h00);
      checkOutput("dis d0 seg", seg_o, 8'h00);
      stepTo(37);
      checkOutput("dp d1 seg", seg_o, 8'h87);
      checkOutput("dp d1 an", an_o, 8'h02);
      applyStimulus(40, 32'h9999_9999, 8'hFF, 8'h00, 8'h00, 1'b0);
      checkOutput("mid pending set", pending_o, 1'b1);
      stepTo(50);
      rst     = 1'b1;
      load    = 1'b1;
      data_in = 32'hAAAA_AAAA;
      @(negedge clk);
      rst  = 1'b0;
      load = 1'b0;
      cyc  = 0;
      checkOutput("mid rst pending", pending_o, 1'b0);
      checkOutput("mid rst seg", seg_o, 8'h00);
      checkOutput("mid rst an", an_o, 8'h00);
      stepTo(1);
      checkOutput("mid rst d0 an", an_o, 8'h01);
      checkOutput("mid rst d0 seg", seg_o, 8'h3F);
      stepTo(33);
      checkOutput("mid rst f1 d0 an", an_o, 8'h01);
      checkOutput("mid rst f1 d0 seg", seg_o, 8'h3F);
      stepTo(41);
      checkOutput("mid rst f1 d2 seg", seg_o, 8'h3F);
      checkOutput("mid rst f1 pending", pending_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
